// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, PS/2 command bytes and packet byte1 bit positions
package ps2_pkg;
  typedef enum logic [2:0] {SEND_EN, WAIT_TX, WAIT_ACK, B1, B2, B3, FAIL} state_t;
  localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam int BIT_L = 0;
  localparam int BIT_R = 1;
  localparam int BIT_M = 2;
  localparam int BIT_SYNC = 3;
  localparam int BIT_XS = 4;
  localparam int BIT_YS = 5;
  localparam int BIT_XO = 6;
  localparam int BIT_YO = 7;
endpackage

// File: rtl/ps2_timeout_cnt.sv
// ps2_timeout_cnt: saturating cycle counter with clear/enable and a runtime limit
// clk, rst_n : clock, async active-low reset
// clr, en    : clear to zero (priority), count enable
// limit      : count value at which done asserts
// done       : count has reached limit
module ps2_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign done = cnt >= limit;
endmodule

// File: rtl/ps2_mouse_packet.sv
// ps2_mouse_packet: enables PS/2 mouse streaming and assembles 3-byte movement packets
// clk_i, rstn_i               : clock, async active-low reset
// rx_data_i, rx_valid_i       : received byte and its strobe
// tx_data_o, tx_req_o         : command byte and send strobe; tx_done_i ends a send
// xm_o, ym_o, btnm_o, ovf_o   : last packet's movement, buttons and overflow
// m_done_tick_o               : new packet strobe; init_err_o : sticky init failure
module ps2_mouse_packet
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int BYTE_TIMEOUT = 500_000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_req_o,
  input  logic       tx_done_i,
  output logic [8:0] xm_o,
  output logic [8:0] ym_o,
  output logic [2:0] btnm_o,
  output logic       m_done_tick_o,
  output logic       ovf_o,
  output logic       init_err_o
);
  localparam int MAXT = ACK_TIMEOUT > BYTE_TIMEOUT ? ACK_TIMEOUT : BYTE_TIMEOUT;
  localparam int W = $clog2(MAXT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_t state, state_n;
  logic [RW-1:0] retry;
  logic [7:0] b1, b2;
  logic send, acc1, acc2, acc3, retry_inc, tmo;
  ps2_timeout_cnt #(.W(W)) u_tmo (
    .clk(clk_i),
    .rst_n(rstn_i),
    .clr(state_n != state),
    .en(state == WAIT_ACK || state == B2 || state == B3),
    .limit(state == WAIT_ACK ? W'(ACK_TIMEOUT) : W'(BYTE_TIMEOUT)),
    .done(tmo)
  );
  // A valid byte is always checked before the timeout so it wins a tie.
  always_comb begin
    state_n = state;
    send = 1'b0;
    acc1 = 1'b0;
    acc2 = 1'b0;
    acc3 = 1'b0;
    retry_inc = 1'b0;
    case (state)
      SEND_EN: begin
        send = 1'b1;
        state_n = WAIT_TX;
      end
      WAIT_TX: state_n = tx_done_i ? WAIT_ACK : WAIT_TX;
      WAIT_ACK:
        if (rx_valid_i && rx_data_i == RSP_ACK) state_n = B1;
        else if (tmo) begin
          retry_inc = retry != RW'(MAX_RETRY);
          state_n = retry_inc ? SEND_EN : FAIL;
        end
      B1:
        if (rx_valid_i && rx_data_i[BIT_SYNC]) begin
          acc1 = 1'b1;
          state_n = B2;
        end
      B2:
        if (rx_valid_i) begin
          acc2 = 1'b1;
          state_n = B3;
        end else if (tmo) state_n = B1;
      B3:
        if (rx_valid_i) begin
          acc3 = 1'b1;
          state_n = B1;
        end else if (tmo) state_n = B1;
      FAIL: state_n = FAIL;
      default: state_n = SEND_EN;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= SEND_EN;
      retry <= '0;
      b1 <= '0;
      b2 <= '0;
      tx_data_o <= '0;
      tx_req_o <= 1'b0;
      xm_o <= '0;
      ym_o <= '0;
      btnm_o <= '0;
      ovf_o <= 1'b0;
      m_done_tick_o <= 1'b0;
      init_err_o <= 1'b0;
    end else begin
      state <= state_n;
      tx_req_o <= send;
      m_done_tick_o <= acc3;
      init_err_o <= init_err_o | (state_n == FAIL);
      if (send) tx_data_o <= CMD_STREAM_EN;
      if (retry_inc) retry <= retry + 1'b1;
      if (acc1) b1 <= rx_data_i;
      if (acc2) b2 <= rx_data_i;
      if (acc3) begin
        xm_o <= {b1[BIT_XS], b2};
        ym_o <= {b1[BIT_YS], rx_data_i};
        btnm_o <= {b1[BIT_M], b1[BIT_R], b1[BIT_L]};
        ovf_o <= b1[BIT_XO] | b1[BIT_YO];
      end
    end
  end
endmodule
